// File: rtl/fpu_ctrl_pkg.sv
// Shared types for the FP issue sequencer: opcode encoding and controller states.
package fpu_ctrl_pkg;

   localparam int OP_W  = 3;
   localparam int REG_W = 5;

   typedef enum logic [OP_W-1:0] {
      FADD = 3'd0,
      FSUB = 3'd1,
      FMUL = 3'd2,
      FDIV = 3'd3
   } fp_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      WB   = 2'd2
   } fpu_state_t;

   // Legal opcodes occupy 0..3, so the top bit alone marks an illegal op.
   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      return !op[OP_W-1];
   endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// Loadable down-counter that times the FP unit latency; zero marks the last BUSY cycle.
module fpu_lat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (dec) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign zero = (cnt_reg == '0);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer and single-entry scoreboard for the shared multi-cycle FP unit:
// starts the unit, times the op, arbitrates the FP RF write port and raises hazard stalls.
module fpu_issue_ctrl
   import fpu_ctrl_pkg::*;
#(
   parameter int LAT_ADD = 2,
   parameter int LAT_MUL = 3,
   parameter int LAT_DIV = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             issue_valid_i,
   input  logic [OP_W-1:0]  issue_op_i,
   input  logic [REG_W-1:0] issue_rd_i,
   input  logic             fp_rd_use_D_i,
   input  logic [REG_W-1:0] rs1D_i,
   input  logic [REG_W-1:0] rs2D_i,
   input  logic             fp_wr_D_i,
   input  logic [REG_W-1:0] rdD_i,
   input  logic             pipe_fp_we_W_i,
   output logic             fpu_start_o,
   output logic [OP_W-1:0]  fpu_op_o,
   output logic             wb_valid_o,
   output logic [REG_W-1:0] wb_rd_o,
   output logic             stall_o,
   output logic             busy_o
);

   localparam int LAT_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
   localparam int LAT_MAX = (LAT_AM > LAT_DIV) ? LAT_AM : LAT_DIV;
   localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

   fpu_state_t       state_reg, state_next;
   logic [OP_W-1:0]  op_reg;
   logic [REG_W-1:0] rd_reg;
   logic             pending_reg;
   logic             start_reg;
   logic             accept;
   logic             wb_fire;
   logic             cnt_zero;
   logic [CNT_W-1:0] lat_m1;

   // Counter is loaded with latency-1 so the BUSY phase lasts exactly LAT cycles.
   always_comb begin
      lat_m1 = CNT_W'(LAT_ADD - 1);
      case (issue_op_i)
         3'(FMUL): lat_m1 = CNT_W'(LAT_MUL - 1);
         3'(FDIV): lat_m1 = CNT_W'(LAT_DIV - 1);
         default:  ;
      endcase
   end

   fpu_lat_counter #(
      .W(CNT_W)
   ) u_lat_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .load_val (lat_m1),
      .dec      (state_reg == BUSY),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      wb_fire    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (issue_valid_i && is_legal_op(issue_op_i)) begin
               accept     = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (cnt_zero) begin
               state_next = WB;
            end
         end
         WB: begin
            // Pipeline writebacks own the port; retry until it is free.
            if (!pipe_fp_we_W_i) begin
               wb_fire    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_reg      <= '0;
         rd_reg      <= '0;
         pending_reg <= 1'b0;
         start_reg   <= 1'b0;
      end else begin
         start_reg <= accept;
         if (accept) begin
            op_reg      <= issue_op_i;
            rd_reg      <= issue_rd_i;
            pending_reg <= 1'b1;
         end else if (wb_fire) begin
            pending_reg <= 1'b0;
         end
      end
   end

   logic [REG_W-1:0] src_sel [2];
   logic [1:0]       src_hit;

   assign src_sel[0] = rs1D_i;
   assign src_sel[1] = rs2D_i;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign src_hit[gi] = (src_sel[gi] == rd_reg);
      end
   endgenerate

   logic stall_struct, stall_raw, stall_waw;

   assign stall_struct = issue_valid_i && (state_reg != IDLE);
   assign stall_raw    = pending_reg && fp_rd_use_D_i && (|src_hit);
   assign stall_waw    = pending_reg && fp_wr_D_i && (rdD_i == rd_reg);

   assign stall_o     = stall_struct || stall_raw || stall_waw;
   assign fpu_start_o = start_reg;
   assign fpu_op_o    = op_reg;
   assign wb_valid_o  = wb_fire;
   assign wb_rd_o     = rd_reg;
   assign busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomised and directed bench for fpu_issue_ctrl against a cycle-number based reference model.
module tb_fpu_issue_ctrl;

   localparam int LA = 2;
   localparam int LM = 3;
   localparam int LD = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       iv = 1'b0;
   logic [2:0] op = '0;
   logic [4:0] rd = '0;
   logic       use_d = 1'b0;
   logic [4:0] rs1 = '0;
   logic [4:0] rs2 = '0;
   logic       wr_d = 1'b0;
   logic [4:0] rdd = '0;
   logic       pipe_we = 1'b0;

   logic       fpu_start;
   logic [2:0] fpu_op;
   logic       wb_valid;
   logic [4:0] wb_rd;
   logic       stall;
   logic       busy;

   fpu_issue_ctrl #(
      .LAT_ADD(LA), .LAT_MUL(LM), .LAT_DIV(LD)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .issue_valid_i  (iv),
      .issue_op_i     (op),
      .issue_rd_i     (rd),
      .fp_rd_use_D_i  (use_d),
      .rs1D_i         (rs1),
      .rs2D_i         (rs2),
      .fp_wr_D_i      (wr_d),
      .rdD_i          (rdd),
      .pipe_fp_we_W_i (pipe_we),
      .fpu_start_o    (fpu_start),
      .fpu_op_o       (fpu_op),
      .wb_valid_o     (wb_valid),
      .wb_rd_o        (wb_rd),
      .stall_o        (stall),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // Observation log from the DUT, used by the hand-computed pins.
   int         last_start = -100;
   int         last_wb = -100;
   int         last_busy = -100;
   logic [4:0] last_wb_rd = '0;
   int         stall_cnt = 0;
   int         start_cnt = 0;
   int         busy_cnt = 0;
   int         wb_cnt = 0;

   // Reference model: one op in flight, timed by absolute cycle numbers.
   bit         m_inflight = 1'b0;
   int         m_acc = 0;
   int         m_lat = 0;
   logic [4:0] m_rd = '0;
   logic [2:0] m_op = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   function automatic int lat_of(input logic [2:0] o);
      case (o)
         3'd2:    return LM;
         3'd3:    return LD;
         default: return LA;
      endcase
   endfunction

   task automatic model_cmp();
      logic e_start, e_wb, e_stall, e_busy;
      if (!reset) begin
         chk("rst_start", fpu_start, 0);
         chk("rst_op", fpu_op, 0);
         chk("rst_wb", wb_valid, 0);
         chk("rst_wbrd", wb_rd, 0);
         chk("rst_stall", stall, 0);
         chk("rst_busy", busy, 0);
         m_inflight = 1'b0;
         m_rd = '0;
         m_op = '0;
         return;
      end
      e_start = m_inflight && (cyc == m_acc + 1);
      e_wb    = m_inflight && (cyc >= m_acc + m_lat + 1) && !pipe_we;
      e_busy  = m_inflight;
      e_stall = m_inflight && (iv || (use_d && (rs1 == m_rd || rs2 == m_rd)) ||
                               (wr_d && rdd == m_rd));
      chk("start", fpu_start, e_start);
      chk("fpu_op", fpu_op, m_op);
      chk("wb_valid", wb_valid, e_wb);
      chk("wb_rd", wb_rd, m_rd);
      chk("stall", stall, e_stall);
      chk("busy", busy, e_busy);
      if (fpu_start) begin last_start = cyc; start_cnt++; end
      if (busy) begin last_busy = cyc; busy_cnt++; end
      if (stall) stall_cnt++;
      if (wb_valid) begin
         last_wb = cyc; last_wb_rd = wb_rd; wb_cnt++;
         $display("cyc %0d: writeback f%0d", cyc, wb_rd);
      end
      if (e_wb) begin
         m_inflight = 1'b0;
      end else if (!m_inflight && iv && !op[2]) begin
         m_inflight = 1'b1;
         m_acc = cyc;
         m_lat = lat_of(op);
         m_rd = rd;
         m_op = op;
         $display("cyc %0d: accept op=%0d f%0d", cyc, op, rd);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_cmp();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle_in();
      iv = 0; op = 0; rd = 0; use_d = 0; rs1 = 0; rs2 = 0; wr_d = 0; rdd = 0; pipe_we = 0;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      #1;
      chk("arst_start", fpu_start, 0);
      chk("arst_op", fpu_op, 0);
      chk("arst_wb", wb_valid, 0);
      chk("arst_wbrd", wb_rd, 0);
      chk("arst_stall", stall, 0);
      chk("arst_busy", busy, 0);
      repeat (n) tick();
      reset = 1'b1;
   endtask

   initial begin
      int a, s0, st0, b0, w0;
      idle_in();
      @(posedge clk); #1;
      do_reset(3);
      repeat (2) tick();

      // FADD f3: start at +1, writeback at +3, idle at +4
      a = cyc; iv = 1; op = 3'd0; rd = 5'd3; tick();
      iv = 0; repeat (5) tick();
      chk("fadd_start", last_start - a, 1);
      chk("fadd_wb", last_wb - a, 3);
      chk("fadd_rd", last_wb_rd, 3);
      chk("fadd_busy_end", last_busy - a, 3);

      // FDIV f5, then FMUL waiting in Execute from +2
      a = cyc; s0 = stall_cnt;
      iv = 1; op = 3'd3; rd = 5'd5; tick();
      iv = 0; tick();
      iv = 1; op = 3'd2; rd = 5'd9; repeat (17) tick();
      iv = 0;
      chk("fdiv_wb", last_wb - a, 17);
      chk("fdiv_rd", last_wb_rd, 5);
      chk("struct_stall_cycles", stall_cnt - s0, 16);
      repeat (6) tick();
      chk("fmul_start", last_start - a, 19);
      chk("fmul_wb", last_wb - a, 22);
      chk("fmul_rd", last_wb_rd, 9);

      // RAW on rs2 against pending f7
      a = cyc; iv = 1; op = 3'd0; rd = 5'd7; tick();
      iv = 0; use_d = 1; rs1 = 5'd1; rs2 = 5'd7; s0 = stall_cnt;
      repeat (4) tick();
      use_d = 0;
      chk("raw_stall_cycles", stall_cnt - s0, 3);
      chk("raw_wb", last_wb - a, 3);

      // WAW on f0, which is a real register
      a = cyc; iv = 1; op = 3'd2; rd = 5'd0; tick();
      iv = 0; wr_d = 1; rdd = 5'd0; s0 = stall_cnt;
      repeat (5) tick();
      wr_d = 0;
      chk("waw_stall_cycles", stall_cnt - s0, 4);
      chk("waw_wb", last_wb - a, 4);

      // FMUL f4 blocked by pipeline writebacks for two cycles
      a = cyc; iv = 1; op = 3'd2; rd = 5'd4; tick();
      iv = 0; repeat (3) tick();
      pipe_we = 1; repeat (2) tick();
      pipe_we = 0; repeat (3) tick();
      chk("conflict_wb", last_wb - a, 6);
      chk("conflict_rd", last_wb_rd, 4);

      // Reset during FDIV busy phase abandons the op
      a = cyc; iv = 1; op = 3'd3; rd = 5'd6; tick();
      iv = 0; repeat (4) tick();
      iv = 1; op = 3'd0; rd = 5'd1;
      #1;
      chk("pre_rst_stall", stall, 1);
      chk("pre_rst_busy", busy, 1);
      w0 = wb_cnt;
      do_reset(2);
      iv = 0;
      repeat (20) tick();
      chk("abandoned_wb", wb_cnt - w0, 0);
      a = cyc; iv = 1; op = 3'd1; rd = 5'd2; tick();
      iv = 0; repeat (4) tick();
      chk("post_rst_wb", last_wb - a, 3);
      chk("post_rst_rd", last_wb_rd, 2);

      // Illegal opcode in IDLE is ignored
      s0 = stall_cnt; st0 = start_cnt; b0 = busy_cnt;
      iv = 1; op = 3'd5; rd = 5'd3; repeat (3) tick();
      iv = 0; repeat (2) tick();
      chk("illegal_stall", stall_cnt - s0, 0);
      chk("illegal_start", start_cnt - st0, 0);
      chk("illegal_busy", busy_cnt - b0, 0);

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         iv      = ($urandom_range(0, 9) < 4);
         op      = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
         rd      = 5'($urandom_range(0, 7));
         use_d   = $urandom_range(0, 1) == 1;
         rs1     = 5'($urandom_range(0, 7));
         rs2     = 5'($urandom_range(0, 7));
         wr_d    = $urandom_range(0, 2) == 0;
         rdd     = 5'($urandom_range(0, 7));
         pipe_we = $urandom_range(0, 9) < 3;
         if ($urandom_range(0, 299) == 0) do_reset(2);
         else tick();
      end
      idle_in();
      repeat (25) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Sequencer and scoreboard for the shared multi-cycle FP arithmetic unit beside the 5-stage RISC-V pipeline. It accepts one FP arithmetic op from the Execute stage and starts the FP unit. It times the op by a per-op latency counter and arbitrates the result onto the FP register-file write port against pipeline writebacks (e.g. FLW). It also raises a stall to the hazard unit on structural, RAW and WAW conflicts against the single in-flight destination register.

## Interface
Parameters:
- LAT_ADD, 2, FP unit cycles for FADD/FSUB
- LAT_MUL, 3, FP unit cycles for FMUL
- LAT_DIV, 16, FP unit cycles for FDIV

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- issue_valid_i  in  1  Execute stage holds an FP arithmetic op (already cleared by FlushE)
- issue_op_i  in  3  fp_op_t opcode
- issue_rd_i  in  5  FP destination register
- fp_rd_use_D_i  in  1  Decode instr reads the FP register file
- rs1D_i, rs2D_i  in  5 each  Decode source registers
- fp_wr_D_i  in  1  Decode instr writes the FP register file
- rdD_i  in  5  Decode destination register
- pipe_fp_we_W_i  in  1  pipeline Writeback writes the FP RF this cycle
- fpu_start_o  out  1  one-cycle start pulse to the FP unit
- fpu_op_o  out  3  op latched for the FP unit, held stable while BUSY/WB
- wb_valid_o  out  1  FP unit result written to the FP RF this cycle
- wb_rd_o  out  5  destination for wb_valid_o
- stall_o  out  1  stall request to the hazard unit (StallF/StallD/FlushE)
- busy_o  out  1  state != IDLE

## Operation
- FSM states: IDLE, BUSY, WB.
- IDLE: an op is accepted only if issue_valid_i=1 and issue_op_i is legal (FADD, FSUB, FMUL, FDIV). On acceptance, latch op and rd, load cnt = LAT(op)−1, set the pending flag, and move to BUSY.
- Illegal opcodes are ignored: no acceptance, no stall.
- BUSY: fpu_start_o=1 only in the first BUSY cycle. cnt decrements each cycle. When cnt=0, move to WB.
- WB: if pipe_fp_we_W_i=0, then wb_valid_o=1 with wb_rd_o = latched rd, clear pending, and move to IDLE.
- WB with pipe_fp_we_W_i=1: the pipeline has priority. Stay in WB and retry the next cycle, with no limit on retries.
- A new op is never accepted in the same cycle as a WB completion. It is accepted the next cycle from IDLE.
- stall_o is the OR of three conditions:
  - structural: issue_valid_i and state != IDLE
  - RAW: pending, fp_rd_use_D_i, and (rs1D_i or rs2D_i) equals pending rd
  - WAW: pending, fp_wr_D_i, and rdD_i equals pending rd
- The register-0 comparison applies normally: f0 is a real FP register.
- cnt width is $clog2(max latency) bits. A latency parameter of 1 gives cnt=0, i.e. a single BUSY cycle.

## Timing
- Reset values: fpu_start_o=0, fpu_op_o=0, wb_valid_o=0, wb_rd_o=0, stall_o=0 (no pending), busy_o=0, state=IDLE, pending=0.
- Accept at edge t → fpu_start_o high in cycle t+1. With no write-port conflict, wb_valid_o is high in cycle t+LAT+1: FADD at t+3, FMUL at t+4, FDIV at t+17.
- Each conflict cycle adds one cycle to the writeback.
- stall_o is combinational from inputs and registered state, with no added latency.
- Reset asserted mid-operation: the op is abandoned, no wb_valid_o is produced, and stall_o drops immediately (asynchronous clear).
- fpu_op_o and wb_rd_o change only on acceptance.

## Structure
- Package fpu_ctrl_pkg holds fp_op_t (FADD=0, FSUB=1, FMUL=2, FDIV=3; others illegal) and the state enum fpu_state_t.
- One sub-module, fpu_lat_counter, is natural: load/decrement counter with a zero flag.
- The scoreboard compare stays in the top level.

## Test plan
- FADD f3 accepted at cycle 10 → fpu_start_o high at 11; wb_valid_o high at 13 with wb_rd_o=3; busy_o low at 14.
- FDIV f5 accepted at 0; FMUL in E at cycle 2 → stall_o=1 through cycle 17; FMUL accepted at 18.
- FADD f7 pending; Decode reads rs2D_i=7 → stall_o=1 until the wb_valid_o cycle, then 0.
- FMUL f4 reaches WB while pipe_fp_we_W_i=1 for 2 cycles → wb_valid_o delayed by exactly 2 cycles, with wb_rd_o=4.
- reset driven low during BUSY of FDIV → all outputs 0 at once. After release, no wb_valid_o occurs and a new FADD completes normally.
- issue_op_i=5 with issue_valid_i=1 in IDLE → no start pulse, stall_o=0, busy_o=0.
